// File: rtl/adder_share_arbiter.sv
// Shares one multicycle signed adder between two requesters: arbitrates, latches
// operands, sequences the start/done handshake and returns the result with an ack.
module adder_share_arbiter #(
    parameter int unsigned W          = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [2*W-1:0]   res,
    output logic             busy,
    output logic             gnt,
    output logic             adder_start,
    output logic [W-1:0]     adder_a,
    output logic [W-1:0]     adder_b,
    input  logic             adder_done,
    input  logic [2*W-1:0]   adder_sum
);

    localparam int unsigned RW   = 2 * W;
    localparam int unsigned WD_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            win;
    logic            gnt_nxt;
    logic [W-1:0]    a_nxt;
    logic [W-1:0]    b_nxt;
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_nxt;
    logic [RW-1:0]   res_nxt;
    logic            ack0_nxt;
    logic            ack1_nxt;
    logic            err0_nxt;
    logic            err1_nxt;
    logic            busy_nxt;
    logic            start_nxt;

    // Winner selection; only consulted in IDLE when at least one request is up.
    always_comb begin
        win = gnt;
        if (FIXED_PRIO != 0) begin
            win = ~req0;
        end else if (req0 && req1) begin
            win = ~gnt;
        end else begin
            win = req1;
        end
    end

    // State register plus the datapath registers it steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            gnt         <= 1'b1;
            adder_a     <= '0;
            adder_b     <= '0;
            wd          <= '0;
            res         <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            busy        <= 1'b0;
            adder_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            adder_a     <= a_nxt;
            adder_b     <= b_nxt;
            wd          <= wd_nxt;
            res         <= res_nxt;
            ack0        <= ack0_nxt;
            ack1        <= ack1_nxt;
            err0        <= err0_nxt;
            err1        <= err1_nxt;
            busy        <= busy_nxt;
            adder_start <= start_nxt;
        end
    end

    // Next-state and datapath update; done is only trusted in WAIT, after SETTLE
    // has let any level-high done from the previous operation fall.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        a_nxt     = adder_a;
        b_nxt     = adder_b;
        wd_nxt    = wd;
        res_nxt   = res;
        unique case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nxt = S_START;
                    gnt_nxt   = win;
                    a_nxt     = win ? a1 : a0;
                    b_nxt     = win ? b1 : b0;
                end
            end
            S_START: begin
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                wd_nxt    = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                wd_nxt = wd + WD_W'(1);
                if (adder_done) begin
                    res_nxt   = adder_sum;
                    state_nxt = S_RESP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    res_nxt   = '0;
                    state_nxt = S_FAIL;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            S_FAIL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        err0_nxt  = 1'b0;
        err1_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        start_nxt = 1'b0;
        busy_nxt  = (state_nxt != S_IDLE);
        start_nxt = (state_nxt == S_START);
        ack0_nxt  = (state_nxt == S_RESP) && !gnt_nxt;
        ack1_nxt  = (state_nxt == S_RESP) &&  gnt_nxt;
        err0_nxt  = (state_nxt == S_FAIL) && !gnt_nxt;
        err1_nxt  = (state_nxt == S_FAIL) &&  gnt_nxt;
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomised bench for adder_share_arbiter: a round-robin and a fixed-priority
// instance, each with its own behavioural adder, checked against a transaction model.
module tb_adder_share_arbiter;

    localparam int unsigned W       = 4;
    localparam int unsigned RW      = 2 * W;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_r  [2];
    logic          req0_r [2];
    logic          req1_r [2];
    logic [W-1:0]  a0_r   [2];
    logic [W-1:0]  b0_r   [2];
    logic [W-1:0]  a1_r   [2];
    logic [W-1:0]  b1_r   [2];
    logic          ack0_w [2];
    logic          ack1_w [2];
    logic          err0_w [2];
    logic          err1_w [2];
    logic          busy_w [2];
    logic          gnt_w  [2];
    logic          start_w[2];
    logic [RW-1:0] res_w  [2];
    logic [W-1:0]  aa_w   [2];
    logic [W-1:0]  ab_w   [2];

    int cfg_delay[2];
    bit cfg_hang [2];
    bit cfg_stale[2];
    int last     [2];
    int total = 0;
    int bad   = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        logic          done_m = 1'b0;
        logic [RW-1:0] sum_m  = '0;
        logic [RW-1:0] pend   = '0;
        int            cnt    = 0;
        bit            run    = 1'b0;

        adder_share_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .FIXED_PRIO(d)) u_dut (
            .clk(clk), .rst(rst_r[d]),
            .req0(req0_r[d]), .a0(a0_r[d]), .b0(b0_r[d]),
            .req1(req1_r[d]), .a1(a1_r[d]), .b1(b1_r[d]),
            .ack0(ack0_w[d]), .ack1(ack1_w[d]), .err0(err0_w[d]), .err1(err1_w[d]),
            .res(res_w[d]), .busy(busy_w[d]), .gnt(gnt_w[d]),
            .adder_start(start_w[d]), .adder_a(aa_w[d]), .adder_b(ab_w[d]),
            .adder_done(done_m), .adder_sum(sum_m)
        );

        // Adder: done rises cfg_delay cycles after the start cycle and stays high
        // until the next start; in stale mode the old done lingers one extra cycle.
        always @(posedge clk) begin
            if (start_w[d]) begin
                cnt  <= 1;
                run  <= !cfg_hang[d];
                pend <= RW'(int'($signed(aa_w[d])) + int'($signed(ab_w[d])));
                if (!cfg_stale[d]) done_m <= 1'b0;
            end else begin
                if (cnt == 1) done_m <= 1'b0;
                if (run && cnt == cfg_delay[d] - 1) begin
                    done_m <= 1'b1;
                    sum_m  <= pend;
                    run    <= 1'b0;
                end
                cnt <= cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sv(input logic [W-1:0] x);
        return int'($signed(x));
    endfunction

    // Arbitration rule: fixed priority favours ch0; round-robin favours the non-last owner.
    function automatic int pick(input int d, input logic r0, input logic r1);
        if (d == 1) return r0 ? 0 : 1;
        if (r0 && r1) return (last[d] == 1) ? 0 : 1;
        return r0 ? 0 : 1;
    endfunction

    task automatic do_reset(input int d);
        rst_r[d]  = 1'b1;
        req0_r[d] = 1'b0;
        req1_r[d] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pulses", {ack0_w[d], ack1_w[d], err0_w[d], err1_w[d]}, 0);
        chk("rst_res", res_w[d], 0);
        chk("rst_busy", busy_w[d], 0);
        chk("rst_gnt", gnt_w[d], 1);
        chk("rst_start", start_w[d], 0);
        chk("rst_adder_a", aa_w[d], 0);
        chk("rst_adder_b", ab_w[d], 0);
        rst_r[d] = 1'b0;
        last[d]  = 1;
    endtask

    // Called at a negedge of an IDLE cycle (cycle 0); serves exactly one operation.
    task automatic run_op(input int d, input bit n0, input bit n1,
                          input logic [W-1:0] x0, input logic [W-1:0] y0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1,
                          input int dl, input bit hg, input bit st);
        int w, k, exp_k, starts;
        bit seen, exp_err;
        logic [W-1:0]  ea, eb;
        logic [RW-1:0] exp_res;
        logic [3:0]    exp_kind;
        cfg_delay[d] = dl;
        cfg_hang[d]  = hg;
        cfg_stale[d] = st;
        if (n0 && !req0_r[d]) begin req0_r[d] = 1'b1; a0_r[d] = x0; b0_r[d] = y0; end
        if (n1 && !req1_r[d]) begin req1_r[d] = 1'b1; a1_r[d] = x1; b1_r[d] = y1; end
        if (!req0_r[d] && !req1_r[d]) begin req0_r[d] = 1'b1; a0_r[d] = x0; b0_r[d] = y0; end
        w        = pick(d, req0_r[d], req1_r[d]);
        ea       = (w == 1) ? a1_r[d] : a0_r[d];
        eb       = (w == 1) ? b1_r[d] : b0_r[d];
        exp_err  = hg || (dl > int'(TIMEOUT) + 1);
        exp_k    = exp_err ? 3 + int'(TIMEOUT) : dl + 2;
        exp_res  = exp_err ? '0 : RW'(sv(ea) + sv(eb));
        exp_kind = exp_err ? ((w == 1) ? 4'b0001 : 4'b0010) : ((w == 1) ? 4'b0100 : 4'b1000);
        starts = 0;
        seen   = 1'b0;
        k      = 1;
        while (!seen && k <= int'(TIMEOUT) + 12) begin
            @(negedge clk);
            if (start_w[d]) starts++;
            if (k == 1) begin
                chk("start_pulse", start_w[d], 1);
                chk("adder_a", aa_w[d], ea);
                chk("adder_b", ab_w[d], eb);
            end
            if (k == 2) begin
                if (w == 1) begin a1_r[d] = W'($urandom); b1_r[d] = W'($urandom); end
                else        begin a0_r[d] = W'($urandom); b0_r[d] = W'($urandom); end
            end
            if (ack0_w[d] || ack1_w[d] || err0_w[d] || err1_w[d]) seen = 1'b1;
            else k++;
        end
        if (!seen) begin
            chk("response_seen", 0, 1);
        end else begin
            chk("latency", k, exp_k);
            chk("resp_kind", {ack0_w[d], ack1_w[d], err0_w[d], err1_w[d]}, exp_kind);
            chk("res", res_w[d], exp_res);
            chk("gnt", gnt_w[d], w);
            chk("start_count", starts, 1);
        end
        last[d] = w;
        if (w == 1) req1_r[d] = 1'b0;
        else        req0_r[d] = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy_w[d], 0);
        chk("idle_pulses", {ack0_w[d], ack1_w[d], err0_w[d], err1_w[d], start_w[d]}, 0);
    endtask

    task automatic drain(input int d);
        while (req0_r[d] || req1_r[d]) run_op(d, 1'b0, 1'b0, '0, '0, '0, '0, 5, 1'b0, 1'b0);
    endtask

    task automatic rand_ops(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            run_op(d, bit'($urandom % 2), bit'($urandom % 2),
                   W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(2, 8)), ($urandom % 16) == 0, ($urandom % 4) == 0);
        end
        drain(d);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got=expired exp=finished");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_r[d] = 1'b1; req0_r[d] = 1'b0; req1_r[d] = 1'b0;
            a0_r[d] = 4'h9; b0_r[d] = 4'h6; a1_r[d] = 4'hA; b1_r[d] = 4'h5;
            cfg_delay[d] = 5; cfg_hang[d] = 1'b0; cfg_stale[d] = 1'b0; last[d] = 1;
        end
        @(negedge clk);
        do_reset(0);
        do_reset(1);

        // single requests, unsigned and signed operands
        run_op(0, 1'b1, 1'b0, 4'h3, 4'h2, '0, '0, 5, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, '0, '0, 4'hD, 4'h2, 5, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, '0, '0, 4'h8, 4'h8, 5, 1'b0, 1'b0);

        // contention after reset: grants alternate 0,1,0,1
        do_reset(0);
        run_op(0, 1'b1, 1'b1, 4'h1, 4'h1, 4'h7, 4'h7, 5, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 4'h2, 4'h2, '0, '0, 5, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, '0, '0, 4'h3, 4'h3, 5, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 4'h4, 4'h5, '0, '0, 5, 1'b0, 1'b0);
        drain(0);

        // stale done held through SETTLE must not be captured
        run_op(0, 1'b1, 1'b0, 4'h4, 4'h4, '0, '0, 5, 1'b0, 1'b1);
        run_op(0, 1'b1, 1'b0, 4'h7, 4'hF, '0, '0, 2, 1'b0, 1'b1);

        // watchdog: hung adder, done on the timeout cycle, done one cycle too late
        run_op(0, 1'b1, 1'b0, 4'h3, 4'h3, '0, '0, 5, 1'b1, 1'b0);
        run_op(0, 1'b1, 1'b0, 4'h1, 4'h6, '0, '0, 5, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 4'h2, 4'h2, '0, '0, int'(TIMEOUT) + 1, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, '0, '0, 4'h5, 4'h1, int'(TIMEOUT) + 2, 1'b0, 1'b0);
        run_op(0, 1'b0, 1'b1, '0, '0, 4'hC, 4'hC, 5, 1'b0, 1'b0);

        // reset in WAIT aborts silently; next request is served normally
        cfg_delay[0] = 8; cfg_hang[0] = 1'b0; cfg_stale[0] = 1'b0;
        req0_r[0] = 1'b1; a0_r[0] = 4'h5; b0_r[0] = 4'h6;
        repeat (4) @(negedge clk);
        rst_r[0] = 1'b1; req0_r[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_pulses", {ack0_w[0], ack1_w[0], err0_w[0], err1_w[0], start_w[0]}, 0);
        rst_r[0] = 1'b0; last[0] = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_quiet", {ack0_w[0], ack1_w[0], err0_w[0], err1_w[0], busy_w[0]}, 0);
        end
        run_op(0, 1'b1, 1'b0, 4'h2, 4'h3, '0, '0, 5, 1'b0, 1'b0);

        // fixed priority: ch1 waits while ch0 keeps requesting
        run_op(1, 1'b1, 1'b1, 4'h1, 4'h1, 4'h7, 4'h7, 5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_op(1, 1'b1, 1'b0, W'(i + 2), 4'h1, '0, '0, 5, 1'b0, 1'b0);
        end
        drain(1);

        rand_ops(0, 40);
        rand_ops(1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
